// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART receiver. Synchronises the serial line, samples each
//               bit at its centre and hands complete bytes to the LED driver
//               over a valid/ready handshake. Flags stop-bit errors and
//               bytes dropped because the previous one was still held.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLK_FREQ = 27_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    // Clocks per bit and clocks to the middle of the start bit
    localparam int              c_N    = CLK_FREQ / BAUD;
    localparam int              c_H    = c_N / 2;
    localparam int              c_TW   = $clog2(c_N);
    localparam logic [c_TW-1:0] c_N_M1 = c_TW'(c_N - 1);
    localparam logic [c_TW-1:0] c_H_M1 = c_TW'(c_H - 1);
    localparam logic [c_TW-1:0] c_ONE  = c_TW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_TW-1:0] r_timer;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_sync1;
    logic            r_sync2;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic            r_busy;
    logic            w_rxs;

    assign w_rxs        = r_sync2;
    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;
    assign rx_busy      = r_busy;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM together with the output handshake and status pulses
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Consumer takes the held byte; a completion below may reload it
            if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_timer == c_H_M1) begin
                        r_timer <= '0;
                        if (w_rxs) begin
                            // Line went back high before mid start bit: glitch
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                        end
                    end else begin
                        r_timer <= r_timer + c_ONE;
                    end
                end

                S_DATA: begin
                    if (r_timer == c_N_M1) begin
                        r_timer        <= '0;
                        r_shift[r_idx] <= w_rxs;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_idx   <= 3'd0;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + c_ONE;
                    end
                end

                S_STOP: begin
                    if (r_timer == c_N_M1) begin
                        r_timer <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (!r_valid || rx_ready) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                // Previous byte still unclaimed: drop the new one
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_timer <= r_timer + c_ONE;
                    end
                end

                S_WAIT_HIGH: begin
                    // A held-low line (break) must not be taken as a new start
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte
// Description : Directed self-checking bench for uart_rx_byte at 27 MHz /
//               115200 baud (234 clocks per bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int c_N = 234;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_rx_byte #(
        .CLK_FREQ (27_000_000),
        .BAUD     (115200)
    ) u_dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Start bit plus eight data bits; returns at the negedge where the stop bit begins
    task automatic send_head(input logic [7:0] b);
        uart_rx = 1'b0;
        wait_neg(c_N);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_neg(c_N);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_head(b);
        uart_rx = 1'b1;
        wait_neg(c_N);
    endtask

    // Local negedge numbering: pin falls at 0, stop sample cycle is 2225,
    // completion outputs visible at 2226, frame ends at 2340.
    initial begin
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        sys_rst  = 1'b1;
        wait_neg(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_busy", rx_busy, 0);
        check("rst_ferr", rx_frame_err, 0);
        check("rst_ovr", rx_overrun, 0);
        sys_rst = 1'b0;
        wait_neg(5);

        // 0xA5 with consumer ready: exact completion timing
        rx_ready = 1'b1;
        send_head(8'hA5);
        uart_rx = 1'b1;
        wait_neg(119);
        check("a5_busy_at_stop", rx_busy, 1);
        check("a5_valid_early", rx_valid, 0);
        wait_neg(1);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_ferr", rx_frame_err, 0);
        check("a5_ovr", rx_overrun, 0);
        check("a5_busy_after", rx_busy, 0);
        wait_neg(1);
        check("a5_valid_clr", rx_valid, 0);
        check("a5_data_hold", rx_data, 8'hA5);
        wait_neg(113);
        rx_ready = 1'b0;

        // 50-cycle low glitch: false start
        uart_rx = 1'b0;
        wait_neg(50);
        uart_rx = 1'b1;
        wait_neg(10);
        check("gl_busy_mid", rx_busy, 1);
        wait_neg(59);
        check("gl_busy_sample", rx_busy, 1);
        wait_neg(1);
        check("gl_busy_idle", rx_busy, 0);
        wait_neg(10);
        check("gl_valid", rx_valid, 0);
        check("gl_ferr", rx_frame_err, 0);

        // 0x00 with stop bit low for three bit times
        send_head(8'h00);
        uart_rx = 1'b0;
        wait_neg(119);
        check("fe_ferr_early", rx_frame_err, 0);
        wait_neg(1);
        check("fe_ferr", rx_frame_err, 1);
        check("fe_valid", rx_valid, 0);
        wait_neg(1);
        check("fe_ferr_pulse", rx_frame_err, 0);
        check("fe_busy_wait", rx_busy, 1);
        wait_neg(581);
        uart_rx = 1'b1;
        wait_neg(c_N);
        check("fe_busy_idle", rx_busy, 0);
        check("fe_valid_late", rx_valid, 0);
        send_frame(8'h3C);
        check("3c_valid", rx_valid, 1);
        check("3c_data", rx_data, 8'h3C);
        rx_ready = 1'b1;
        wait_neg(1);
        check("3c_valid_clr", rx_valid, 0);
        rx_ready = 1'b0;

        // Overrun: 0x11 then 0x22 back-to-back with consumer stalled
        send_frame(8'h11);
        send_head(8'h22);
        uart_rx = 1'b1;
        wait_neg(119);
        check("ov_valid_held", rx_valid, 1);
        check("ov_ovr_early", rx_overrun, 0);
        wait_neg(1);
        check("ov_ovr", rx_overrun, 1);
        check("ov_valid", rx_valid, 1);
        check("ov_data", rx_data, 8'h11);
        wait_neg(1);
        check("ov_ovr_pulse", rx_overrun, 0);
        wait_neg(113);
        rx_ready = 1'b1;
        wait_neg(1);
        check("ov_valid_clr", rx_valid, 0);
        rx_ready = 1'b0;

        // Ready arrives on the very cycle the second byte completes
        send_frame(8'h11);
        check("rc_first_valid", rx_valid, 1);
        check("rc_first_data", rx_data, 8'h11);
        send_head(8'h22);
        uart_rx = 1'b1;
        wait_neg(119);
        rx_ready = 1'b1;
        wait_neg(1);
        check("rc_ovr", rx_overrun, 0);
        check("rc_valid", rx_valid, 1);
        check("rc_data", rx_data, 8'h22);
        rx_ready = 1'b0;
        wait_neg(1);
        check("rc_valid_hold", rx_valid, 1);
        wait_neg(113);

        // Asynchronous reset during data bit 4 of 0xFF (0x22 still held)
        uart_rx = 1'b0;
        wait_neg(c_N);
        uart_rx = 1'b1;
        wait_neg(4 * c_N + 100);
        check("ar_busy_pre", rx_busy, 1);
        check("ar_valid_pre", rx_valid, 1);
        sys_rst = 1'b1;
        #1;
        check("ar_valid", rx_valid, 0);
        check("ar_data", rx_data, 8'h00);
        check("ar_busy", rx_busy, 0);
        check("ar_ferr", rx_frame_err, 0);
        check("ar_ovr", rx_overrun, 0);
        wait_neg(2);
        sys_rst = 1'b0;
        wait_neg(5);
        send_frame(8'h5A);
        check("5a_valid", rx_valid, 1);
        check("5a_data", rx_data, 8'h5A);
        check("5a_ferr", rx_frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_byte.md
# uart_rx_byte

UART receiver that deserialises the board's serial input line into bytes and presents them on a valid/ready handshake. It sits directly upstream of the LED display logic: each received byte is handed to the 6-LED driver, which latches it as the new LED pattern. Operates in the single 27 MHz system clock domain; the asynchronous serial input is synchronised internally.

## Interface
- CLK_FREQ, 27_000_000, system clock frequency in Hz
- BAUD, 115200, serial bit rate; N = CLK_FREQ/BAUD (integer division, 234 at defaults), H = N/2 (117)
- sys_clk  input  1  system clock; all logic on rising edge
- sys_rst  input  1  reset, asynchronous, active-high
- uart_rx  input  1  serial line, idle high, 8N1, LSB first
- rx_data  output  8  received byte; stable while rx_valid high
- rx_valid  output  1  byte available; held until accepted
- rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready on a rising edge
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
- rx_overrun  output  1  one-cycle pulse: new byte completed while previous still held
- rx_busy  output  1  high whenever FSM is not IDLE

## Operation
- uart_rx passes through a 2-FF synchroniser (both FFs reset to 1); FSM sees only the synchronised bit `rxs`.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on rxs==0 -> START, bit-timer cleared.
- START: sample rxs when H cycles have elapsed in START; rxs==1 -> IDLE (false start, no output); rxs==0 -> DATA, bit index 0.
- DATA: sample rxs every N cycles; shift into bit[index], LSB first; after index 7 -> STOP.
- STOP: sample rxs after N cycles. rxs==1 -> byte complete, -> IDLE. rxs==0 -> pulse rx_frame_err, discard byte, -> WAIT_HIGH.
- WAIT_HIGH: remain until rxs==1, then -> IDLE (break condition never retriggers a start).
- Byte complete, output side:
  - rx_valid==0: load rx_data, set rx_valid.
  - rx_valid==1 and rx_ready==1 same cycle: old byte accepted, new byte loaded, rx_valid stays 1.
  - rx_valid==1 and rx_ready==0: pulse rx_overrun, new byte dropped, rx_data/rx_valid unchanged.
- rx_valid & rx_ready with no completion: rx_valid clears next edge; rx_data holds last value.
- Bit timer width = clog2(N); index 3 bits; no wrap beyond N-1 (cleared at each sample point).
- Reset (any time, including mid-frame): FSM -> IDLE, timer/index 0, shift register 0, rx_data 8'h00, rx_valid 0, rx_frame_err 0, rx_overrun 0, rx_busy 0, synchroniser 1. Partial frame is lost; first falling edge after reset release starts a new frame.

## Timing
- Let t0 = first cycle rxs==0 in IDLE (pin fall + 2 cycles).
- Sample points: start t0+H, data bit k (0..7) t0+H+(k+1)·N, stop t0+H+9·N.
- rx_valid (or rx_frame_err / rx_overrun) asserted at t0+H+9·N+1; defaults: t0+2224.
- FSM back in IDLE on the cycle after the stop sample; a new start edge may be detected in that cycle (supports back-to-back frames with zero idle time).
- rx_frame_err, rx_overrun: exactly one cycle high.
- rx_busy high from t0+1 through the stop-sample cycle (and throughout WAIT_HIGH).

## Test plan
- Reset, send 0xA5 at 115200 (234 clk/bit), rx_ready=1 -> rx_valid one cycle at t0+2224, rx_data=8'hA5, no error pulses.
- Low glitch of 50 cycles on uart_rx -> no rx_valid, rx_busy returns low after H cycles in START, FSM in IDLE.
- Send 0x00 with stop bit held low for 3 bit-times -> rx_frame_err single pulse, rx_valid stays 0; then 0x3C -> rx_data=8'h3C, valid.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_valid held, rx_data=8'h11, rx_overrun pulse at second stop; raise rx_ready -> rx_valid clears next cycle.
- rx_ready asserted exactly on the completion cycle of second byte (0x11 held, 0x22 arriving) -> no overrun, rx_data=8'h22, rx_valid stays 1.
- Assert sys_rst during data bit 4 of 0xFF -> all outputs 0 immediately (asynchronous); release, send 0x5A -> rx_data=8'h5A.
